// File: rtl/lib_uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package lib_uart;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } UART_TX_STATE;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU serial-write handshake: execute stage offers bytes, responder reports busy.
interface uart_tx_ctrl_if;
  logic       w_req;
  logic [7:0] w_data;
  logic       w_busy;

  modport master (output w_req, output w_data, input  w_busy);
  modport slave  (input  w_req, input  w_data, output w_busy);
endinterface

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop frees a slot that cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter fed by the CPU write handshake through a small FIFO.
module uart_tx_ctrl
  import lib_uart::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  wr,
  output logic           uart_tx,
  output logic           tx_active
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  UART_TX_STATE                 state_q;
  logic [CW-1:0]                cnt_q;
  logic [2:0]                   bit_q;
  logic [7:0]                   shift_q;
  logic                         tx_q;
  logic                         bit_end;
  logic                         pop;
  logic                         empty;
  logic [7:0]                   head;
  logic [$clog2(FIFO_DEPTH):0]  count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr.w_req),
    .pop_i   (pop),
    .wdata_i (wr.w_data),
    .rdata_o (head),
    .count_o (count),
    .full_o  (wr.w_busy),
    .empty_o (empty)
  );

  assign bit_end   = (cnt_q == CNT_MAX);
  // Pop decision uses the registered count, so a push never races its own pop.
  assign pop       = !empty && ((state_q == IDLE) || (state_q == STOP && bit_end));
  assign uart_tx   = tx_q;
  assign tx_active = (state_q != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (!empty) begin
            shift_q <= head;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q != 3'd7) begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              shift_q <= head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Checks uart_tx_ctrl cycle by cycle against a frame-timeline model with a byte queue.
module tb_uart_tx_ctrl;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx, tx_active;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (bus.slave),
    .uart_tx   (uart_tx),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model: queue of accepted bytes plus the current frame's data and age.
  logic [7:0]  m_q[$];
  bit          m_active = 1'b0;
  int unsigned m_t = 0;
  logic [7:0]  m_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int unsigned p;
    if (!m_active) return 1'b1;
    p = m_t / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_data[p-1];
  endfunction

  function automatic logic exp_busy();
    return m_q.size() == DEPTH;
  endfunction

  task automatic model_edge(input logic r, input logic req, input logic [7:0] d);
    bit full_before;
    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_t = 0;
      return;
    end
    full_before = (m_q.size() == DEPTH);
    if (!m_active || m_t == FRAME - 1) begin
      if (m_q.size() > 0) begin
        m_data = m_q.pop_front();
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
    end
    if (req && !full_before) m_q.push_back(d);
  endtask

  task automatic step(input logic r, input logic req, input logic [7:0] d);
    rst = r;
    bus.w_req = req;
    bus.w_data = d;
    @(posedge clk);
    model_edge(r, req, d);
    #1;
    check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
    check("w_busy", {31'd0, bus.w_busy}, {31'd0, exp_busy()});
    check("tx_active", {31'd0, tx_active}, {31'd0, (m_active || m_q.size() > 0)});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.w_req = 1'b0;
    bus.w_data = '0;

    // Reset, then quiet line
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    idle(100);

    // Single byte: start bit on the following edge
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 8'h00);
    check("latency_start_low", {31'd0, uart_tx}, 32'd0);
    idle(FRAME + 10);

    // Five consecutive writes, back-to-back frames
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i));
    check("busy_after_five", {31'd0, bus.w_busy}, 32'd1);
    idle(5 * FRAME + 10);

    // Full FIFO: 0xFF offered only while busy must be dropped
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h30 + 8'(i));
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, exp_busy(), 8'hFF);
    idle(6 * FRAME);

    // Reset during third data bit with two bytes queued
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h81);
    step(1'b0, 1'b1, 8'h7E);
    for (int i = 0; i < 200 && !(m_active && m_t / CPB == 3); i++) step(1'b0, 1'b0, 8'h00);
    check("reached_data_bit", {31'd0, (m_active && m_t / CPB == 3)}, 32'd1);
    step(1'b1, 1'b0, 8'h00);
    idle(3 * FRAME);

    // Push landing on the stop-bit-end edge with an empty FIFO
    step(1'b0, 1'b1, 8'h12);
    for (int i = 0; i < 200 && !(m_active && m_t == FRAME - 2); i++) step(1'b0, 1'b0, 8'h00);
    check("reached_stop_end", {31'd0, (m_active && m_t == FRAME - 2)}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    check("idle_gap_high", {31'd0, uart_tx}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    check("start_after_gap", {31'd0, uart_tx}, 32'd0);
    idle(FRAME + 5);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end
    idle(DEPTH * FRAME + FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
